// File: rtl/ps2_pkg.sv
// Shared types, frame constants and parity helper for the PS/2 receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  // Odd-parity bit that a correct frame carries for the given byte.
  function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_rx_if.sv
// Byte-stream side of the PS/2 receiver: head-of-FIFO data, pop, status pulses.
interface ps2_rx_if;
  import ps2_pkg::*;

  logic [PS2_DATA_BITS-1:0] rx_data;
  logic                     rx_valid;
  logic                     rx_rd;
  logic                     rx_overflow;
  logic                     ovf_clr;
  logic                     parity_err;
  logic                     frame_err;
  logic                     busy;

  modport master (
    output rx_data, rx_valid, rx_overflow, parity_err, frame_err, busy,
    input  rx_rd, ovf_clr
  );

  modport slave (
    input  rx_data, rx_valid, rx_overflow, parity_err, frame_err, busy,
    output rx_rd, ovf_clr
  );
endinterface

// File: rtl/ps2_fifo.sv
// Generic show-ahead synchronous FIFO; head entry is always visible on dout.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module ps2_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS:0]   count;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == (DEPTH_BITS + 1)'(0));
  assign full    = (count == (DEPTH_BITS + 1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage, wrapping pointers and occupancy count
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + DEPTH_BITS'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + DEPTH_BITS'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (DEPTH_BITS + 1)'(1);
        2'b01:   count <= count - (DEPTH_BITS + 1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ps2_rx.sv
// PS/2 receiver: synchronise + deglitch clock/data, deframe 11-bit frames,
// check start/parity/stop, abort stalled frames, buffer bytes in a FIFO.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER    = 8,
  parameter int TIMEOUT   = 8192,
  parameter int FIFO_BITS = 3
) (
  input  logic     clk_sys,
  input  logic     reset,
  input  logic     ps2_clk,
  input  logic     ps2_data,
  ps2_rx_if.master bus
);
  localparam int FCW = $clog2(FILTER + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam int BCW = $clog2(PS2_DATA_BITS);

  logic [1:0] raw_lines;
  logic [1:0] flt_lines;

  assign raw_lines = {ps2_data, ps2_clk};

  for (genvar i = 0; i < 2; i++) begin : g_filt
    logic [1:0]     sync;
    logic [FCW-1:0] stable_cnt;
    logic           level;

    // Two-flop synchroniser, then accept a new level only after FILTER steady cycles
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        sync       <= 2'b11;
        stable_cnt <= '0;
        level      <= 1'b1;
      end else begin
        sync <= {sync[0], raw_lines[i]};
        if (sync[1] != level) begin
          if (stable_cnt == FCW'(FILTER - 1)) begin
            level      <= sync[1];
            stable_cnt <= '0;
          end else begin
            stable_cnt <= stable_cnt + FCW'(1);
          end
        end else begin
          stable_cnt <= '0;
        end
      end
    end

    assign flt_lines[i] = level;
  end

  logic                     clk_q;
  logic                     sample;
  logic                     din;
  ps2_state_t               state;
  ps2_state_t               nxt;
  logic [PS2_DATA_BITS-1:0] shreg;
  logic [BCW-1:0]           bitcnt;
  logic                     perr_flag;
  logic [TCW-1:0]           tcnt;
  logic                     tmo;
  logic                     push;
  logic                     perr_evt;
  logic                     ferr_evt;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [PS2_DATA_BITS-1:0] fifo_dout;
  logic                     drop;

  assign sample = clk_q & ~flt_lines[0];
  assign din    = flt_lines[1];
  assign tmo    = (state != IDLE) && (tcnt == TCW'(TIMEOUT));

  // Previous filtered clock level for falling-edge detection
  always_ff @(posedge clk_sys) begin
    if (reset) clk_q <= 1'b1;
    else       clk_q <= flt_lines[0];
  end

  // FSM state register
  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // FSM next state; a sample in the same cycle as a timeout wins
  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (sample && !din) nxt = DATA;
        else                nxt = IDLE;
      end
      DATA: begin
        if (sample) begin
          if (bitcnt == BCW'(PS2_DATA_BITS - 1)) nxt = PARITY;
          else                                   nxt = DATA;
        end else if (tmo) begin
          nxt = IDLE;
        end else begin
          nxt = DATA;
        end
      end
      PARITY: begin
        if (sample)   nxt = STOP;
        else if (tmo) nxt = IDLE;
        else          nxt = PARITY;
      end
      STOP: begin
        if (sample || tmo) nxt = IDLE;
        else               nxt = STOP;
      end
      default: nxt = IDLE;
    endcase
  end

  // FSM outputs: frame verdict at the stop sample, or abort on timeout
  always_comb begin
    push     = 1'b0;
    perr_evt = 1'b0;
    ferr_evt = 1'b0;
    if (state == STOP && sample) begin
      if (!din)           ferr_evt = 1'b1;
      else if (perr_flag) perr_evt = 1'b1;
      else                push     = 1'b1;
    end else if (tmo) begin
      ferr_evt = 1'b1;
    end else begin
      push = 1'b0;
    end
  end

  // Shift register, bit counter, parity verdict and inter-edge timeout counter
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      shreg     <= '0;
      bitcnt    <= '0;
      perr_flag <= 1'b0;
      tcnt      <= '0;
    end else begin
      if (state == IDLE || sample) tcnt <= '0;
      else                         tcnt <= tcnt + TCW'(1);
      if (sample) begin
        case (state)
          IDLE: begin
            bitcnt    <= '0;
            perr_flag <= 1'b0;
          end
          DATA: begin
            shreg  <= {din, shreg[PS2_DATA_BITS-1:1]};
            bitcnt <= bitcnt + BCW'(1);
          end
          PARITY:  perr_flag <= (din != odd_parity(shreg));
          default: perr_flag <= perr_flag;
        endcase
      end
    end
  end

  ps2_fifo #(
    .WIDTH      (PS2_DATA_BITS),
    .DEPTH_BITS (FIFO_BITS)
  ) u_fifo (
    .clk   (clk_sys),
    .reset (reset),
    .push  (push),
    .din   (shreg),
    .pop   (bus.rx_rd),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A full FIFO still accepts the byte if the head is popped in the same cycle
  assign drop = push & fifo_full & ~bus.rx_rd;

  // Registered error pulses and sticky overflow (set beats clear)
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bus.parity_err  <= 1'b0;
      bus.frame_err   <= 1'b0;
      bus.rx_overflow <= 1'b0;
    end else begin
      bus.parity_err <= perr_evt;
      bus.frame_err  <= ferr_evt;
      if (drop)             bus.rx_overflow <= 1'b1;
      else if (bus.ovf_clr) bus.rx_overflow <= 1'b0;
      else                  bus.rx_overflow <= bus.rx_overflow;
    end
  end

  assign bus.rx_data  = fifo_dout;
  assign bus.rx_valid = ~fifo_empty;
  assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: frame driver pushes expected events, a monitor
// pops and compares on every byte / error pulse the receiver presents.
module tb_ps2_rx;
  import ps2_pkg::*;

  localparam int FILTER    = 8;
  localparam int TIMEOUT   = 8192;
  localparam int FIFO_BITS = 2;
  localparam int HALF      = 80;

  localparam int K_BYTE = 0;
  localparam int K_PERR = 1;
  localparam int K_FERR = 2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } ev_t;

  logic clk_sys  = 1'b0;
  logic reset    = 1'b1;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;
  logic main_rd  = 1'b0;
  logic mon_rd   = 1'b0;
  logic ovf_drv  = 1'b0;
  bit   auto_rd  = 1'b0;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  ps2_rx_if bus ();
  assign bus.rx_rd   = main_rd | mon_rd;
  assign bus.ovf_clr = ovf_drv;

  ps2_rx #(
    .FILTER    (FILTER),
    .TIMEOUT   (TIMEOUT),
    .FIFO_BITS (FIFO_BITS)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] data);
    ev_t e;
    e.kind = 2'(kind);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic mon_event(input int kind, input logic [7:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got kind %0d data 0x%02h, scoreboard empty", kind, data);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      if (kind == K_BYTE) check("rx_data", 32'(data), 32'(e.data));
    end
  endtask

  // Monitor: compare every output event against the scoreboard, auto-pop bytes
  initial begin
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        mon_rd = 1'b0;
      end else begin
        if (bus.parity_err) mon_event(K_PERR, 8'h00);
        if (bus.frame_err)  mon_event(K_FERR, 8'h00);
        if (mon_rd) begin
          mon_rd = 1'b0;
        end else if (auto_rd && bus.rx_valid) begin
          mon_event(K_BYTE, bus.rx_data);
          mon_rd = 1'b1;
        end
      end
    end
  end

  // Drive one PS/2 frame (or its first nbits bits), optionally with glitches,
  // a pop aligned to the stop sample, or push-latency checks around it.
  task automatic send_frame(input logic [7:0] b, input bit pflip, input bit stop,
                            input int nbits, input int half, input bit glitch,
                            input bit pop_stop, input bit chk_lat);
    logic [PS2_FRAME_BITS-1:0] fr;
    fr = {stop, (~^b) ^ pflip, b, 1'b0};
    for (int k = 0; k < nbits; k++) begin
      @(negedge clk_sys);
      ps2_data = fr[k];
      for (int i = 1; i <= half; i++) begin
        @(negedge clk_sys);
        if (glitch && i == half / 2)     ps2_clk = 1'b0;
        if (glitch && i == half / 2 + 3) ps2_clk = 1'b1;
      end
      ps2_clk = 1'b0;
      for (int i = 1; i <= half; i++) begin
        @(negedge clk_sys);
        if (glitch && i == half / 2)     ps2_data = ~fr[k];
        if (glitch && i == half / 2 + 5) ps2_data = fr[k];
        if (k == 10) begin
          main_rd = pop_stop && (i == 2 + FILTER);
          if (chk_lat && i == 2 + FILTER) check("valid_before_push", 32'(bus.rx_valid), 32'd0);
          if (chk_lat && i == 3 + FILTER) check("valid_after_push", 32'(bus.rx_valid), 32'd1);
          if (chk_lat && i == 4 + FILTER) check("valid_after_pop", 32'(bus.rx_valid), 32'd0);
        end
      end
      ps2_clk = 1'b1;
    end
    @(negedge clk_sys);
    ps2_data = 1'b1;
    main_rd  = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Bounded wait for the monitor to consume all expected events
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk_sys);
      n++;
    end
    gap(4);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'd0);
    check({tag, "_rx_data"}, 32'(bus.rx_data), 32'h00);
    check({tag, "_rx_overflow"}, 32'(bus.rx_overflow), 32'd0);
    check({tag, "_parity_err"}, 32'(bus.parity_err), 32'd0);
    check({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  // Watchdog: the run must always end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    gap(5);
    check_reset_outputs("reset");
    reset = 1'b0;
    gap(20);
    auto_rd = 1'b1;

    // Good byte at 2000-cycle bit period with push/pop latency checks
    expect_ev(K_BYTE, 8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1000, 1'b0, 1'b0, 1'b1);
    drain("drain_1c");

    // Bad parity, then bad stop bit
    expect_ev(K_PERR, 8'h00);
    send_frame(8'h1C, 1'b1, 1'b1, 11, HALF, 1'b0, 1'b0, 1'b0);
    gap(30);
    check("valid_after_perr", 32'(bus.rx_valid), 32'd0);
    drain("drain_perr");
    expect_ev(K_FERR, 8'h00);
    send_frame(8'hF0, 1'b0, 1'b0, 11, HALF, 1'b0, 1'b0, 1'b0);
    gap(30);
    check("valid_after_ferr", 32'(bus.rx_valid), 32'd0);
    drain("drain_ferr");

    // Start + 4 data bits then a stalled clock
    expect_ev(K_FERR, 8'h00);
    send_frame(8'h5A, 1'b0, 1'b1, 5, HALF, 1'b0, 1'b0, 1'b0);
    check("busy_mid_frame", 32'(bus.busy), 32'd1);
    gap(TIMEOUT + 2);
    check("busy_after_timeout", 32'(bus.busy), 32'd0);
    drain("drain_timeout");
    expect_ev(K_BYTE, 8'hAA);
    send_frame(8'hAA, 1'b0, 1'b1, 11, HALF, 1'b0, 1'b0, 1'b0);
    drain("drain_aa");

    // Overflow with depth 4: 0x05 is dropped
    auto_rd = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      if (b <= 4) expect_ev(K_BYTE, 8'(b));
      send_frame(8'(b), 1'b0, 1'b1, 11, HALF, 1'b0, 1'b0, 1'b0);
    end
    gap(30);
    check("overflow_set", 32'(bus.rx_overflow), 32'd1);
    check("head_after_ovf", 32'(bus.rx_data), 32'h01);
    auto_rd = 1'b1;
    drain("drain_ovf");
    check("valid_after_drain", 32'(bus.rx_valid), 32'd0);
    check("overflow_sticky", 32'(bus.rx_overflow), 32'd1);
    ovf_drv = 1'b1;
    gap(1);
    ovf_drv = 1'b0;
    gap(1);
    check("overflow_cleared", 32'(bus.rx_overflow), 32'd0);

    // Push coinciding with a pop while full: 0x11 leaves, 0x55 enters
    auto_rd = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 11, HALF, 1'b0, 1'b0, 1'b0);
    expect_ev(K_BYTE, 8'h22);
    send_frame(8'h22, 1'b0, 1'b1, 11, HALF, 1'b0, 1'b0, 1'b0);
    expect_ev(K_BYTE, 8'h33);
    send_frame(8'h33, 1'b0, 1'b1, 11, HALF, 1'b0, 1'b0, 1'b0);
    expect_ev(K_BYTE, 8'h44);
    send_frame(8'h44, 1'b0, 1'b1, 11, HALF, 1'b0, 1'b0, 1'b0);
    expect_ev(K_BYTE, 8'h55);
    send_frame(8'h55, 1'b0, 1'b1, 11, HALF, 1'b0, 1'b1, 1'b0);
    gap(30);
    check("no_ovf_push_pop", 32'(bus.rx_overflow), 32'd0);
    check("head_after_push_pop", 32'(bus.rx_data), 32'h22);
    auto_rd = 1'b1;
    drain("drain_push_pop");

    // Glitches on clock and data must be filtered out
    expect_ev(K_BYTE, 8'hE0);
    send_frame(8'hE0, 1'b0, 1'b1, 11, HALF, 1'b1, 1'b0, 1'b0);
    drain("drain_glitch");

    // Reset mid-frame discards the partial byte and the FIFO contents
    auto_rd = 1'b0;
    send_frame(8'h77, 1'b0, 1'b1, 11, HALF, 1'b0, 1'b0, 1'b0);
    gap(30);
    check("fifo_before_reset", 32'(bus.rx_valid), 32'd1);
    send_frame(8'h3C, 1'b0, 1'b1, 7, HALF, 1'b0, 1'b0, 1'b0);
    check("busy_before_reset", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    gap(3);
    check_reset_outputs("midreset");
    reset = 1'b0;
    gap(20);
    auto_rd = 1'b1;
    expect_ev(K_BYTE, 8'h12);
    send_frame(8'h12, 1'b0, 1'b1, 11, HALF, 1'b0, 1'b0, 1'b0);
    drain("drain_12");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
